uart_rx_cfg: RTL
================

UART_RX_CFG -- requirements
Module: uart_rx_cfg

Interface
REQ-001 Parameter CLK_HZ, default 27000000, input clock frequency in Hz.
REQ-002 Parameter BAUD, default 115200, line bit rate; DIV = CLK_HZ/BAUD (integer division, 234 at defaults); DIV SHALL be >= 8.
REQ-003 Parameter DATA_BITS, default 8, data bits per frame, legal 5..8.
REQ-004 Parameter PARITY, default 0, parity mode: 0 none, 1 odd, 2 even.
REQ-005 Parameter STOP_BITS, default 1, stop bits checked, legal 1 or 2.
REQ-006 clock  input  1  single clock for all logic.
REQ-007 rst  input  1  asynchronous, active-low reset.
REQ-008 rx  input  1  asynchronous serial line, idle high, LSB first.
REQ-009 data  output  DATA_BITS  received word, valid while valid=1.
REQ-010 valid  output  1  word available; held until accepted.
REQ-011 ready  input  1  consumer accepts the word when valid=1 and ready=1 in the same cycle.
REQ-012 frame_err  output  1  stop-bit error for the word in data; qualified by valid.
REQ-013 parity_err  output  1  parity mismatch for the word in data; qualified by valid; always 0 when PARITY=0.
REQ-014 overrun  output  1  sticky flag: at least one frame was dropped.
REQ-015 busy  output  1  high in every state except IDLE.

Function
REQ-016 rx SHALL pass through a 2-flop synchronizer; all decisions SHALL use the synchronized value rxs.
REQ-017 States SHALL be: IDLE, START, DATA, PARITY (skipped when PARITY=0), STOP, BREAK.
REQ-018 The bit counter SHALL run 0..DIV-1 per bit period, be $clog2(DIV) bits wide and restart at 0 at each bit boundary.
REQ-019 IDLE->START on the first cycle rxs=0; the counter SHALL be 0 in that cycle.
REQ-020 Each bit SHALL be sampled at counts DIV/2-1, DIV/2 and DIV/2+1; the bit value is the 2-of-3 majority, decided at count DIV/2+1.
REQ-021 START: a majority of 1 SHALL return to IDLE (glitch reject) with no flags changed; a majority of 0 SHALL continue to DATA after the count reaches DIV-1.
REQ-022 DATA: shift DATA_BITS bits LSB first into an internal shift register; then go to PARITY or STOP.
REQ-023 PARITY: odd mode requires the XOR of the data bits and the parity bit to be 1; even mode requires it to be 0.
REQ-024 STOP: each stop bit SHALL be decided as in REQ-020; a 0 on any checked stop bit SHALL set the frame error for that word.
REQ-025 The frame SHALL complete at the decision of the last stop bit (mid-bit), not at the end of the bit.
REQ-026 On completion with a stop error, go to BREAK; otherwise go to IDLE.
REQ-027 BREAK SHALL wait until rxs=1 and then go to IDLE, so a held-low line yields exactly one frame.
REQ-028 On completion with valid=0, or with valid=1 and ready=1 in the same cycle, the next cycle SHALL load data, frame_err and parity_err and drive valid=1.
REQ-029 On completion with valid=1 and ready=0, the new frame SHALL be discarded, data and flags SHALL be unchanged, and overrun SHALL be set to 1 the next cycle.
REQ-030 The handshake valid=1 with ready=1 SHALL clear valid the next cycle unless REQ-028 reloads it.
REQ-031 overrun SHALL stay set until the next accepted handshake clears it; if a set occurs in the same cycle as a clear, the set wins.
REQ-032 Latency: with the synchronized falling edge at cycle T0, valid SHALL rise at T0 + (1+DATA_BITS+P+STOP_BITS-1)*DIV + DIV/2 + 2, where P = 1 if PARITY != 0 else 0; pin-to-rxs delay is 2 cycles.

Reset
REQ-033 While rst=0: state IDLE, counters 0, shift register 0, synchronizer flops 1, data 0, and valid, frame_err, parity_err, overrun and busy all 0.
REQ-034 Reset asserted mid-frame SHALL abandon the frame with no output change after release; reception restarts on the next falling edge.

Verification (defaults unless stated, DIV=234)
REQ-035 8N1 byte 0x55, ready=1 -> data=0x55, valid high 1 cycle, rising at T0+2225, frame_err=0, parity_err=0.
REQ-036 Start glitch low for 50 cycles -> return to IDLE, valid stays 0, busy drops by T0+119.
REQ-037 PARITY=2, byte 0xA3 sent with parity bit 1 -> parity_err=1, data=0xA3; resent with parity bit 0 -> parity_err=0.
REQ-038 Stop bit forced 0, then line held low 5 bit times -> one word with frame_err=1, BREAK held until rx=1, no second word.
REQ-039 ready=0, two bytes 0x11 then 0x22 -> data stays 0x11, overrun=1; raise ready -> overrun clears the next cycle.
REQ-040 rst pulsed low during bit 4 of 0x3C, then 0x7E sent -> only 0x7E delivered, all outputs 0 during reset.

Source files
------------

// File: rtl/uart_rx_cfg.sv
// uart_rx_cfg: configurable UART receiver with a valid/ready word output.
//   clock       single clock for all logic
//   rst         asynchronous active-low reset
//   rx          asynchronous serial line, idle high, LSB first
//   data        received word, valid while valid=1
//   valid       word available, held until accepted (valid & ready)
//   ready       consumer accept
//   frame_err   stop-bit error for the word in data (qualified by valid)
//   parity_err  parity mismatch for the word in data (qualified by valid)
//   overrun     sticky: a completed frame was dropped because data was still held
//   busy        receiver is not idle
// Every bit is voted 2-of-3 around its middle. The frame completes at the
// decision point of the last stop bit, so the next start edge is never missed.
module uart_rx_cfg #(
    parameter int CLK_HZ    = 27000000,
    parameter int BAUD      = 115200,
    parameter int DATA_BITS = 8,
    parameter int PARITY    = 0,
    parameter int STOP_BITS = 1
) (
    input  logic                 clock,
    input  logic                 rst,
    input  logic                 rx,
    input  logic                 ready,
    output logic [DATA_BITS-1:0] data,
    output logic                 valid,
    output logic                 frame_err,
    output logic                 parity_err,
    output logic                 overrun,
    output logic                 busy
);

    localparam int DIV = CLK_HZ / BAUD;
    localparam int CW  = $clog2(DIV);

    localparam logic [CW-1:0] CNT_ONE  = CW'(1);
    localparam logic [CW-1:0] CNT_LAST = CW'(DIV - 1);
    localparam logic [CW-1:0] SMP_A    = CW'(DIV / 2 - 1);
    localparam logic [CW-1:0] SMP_B    = CW'(DIV / 2);
    localparam logic [CW-1:0] SMP_C    = CW'(DIV / 2 + 1);
    localparam logic [2:0]    DATA_LAST = 3'(DATA_BITS - 1);
    localparam logic [2:0]    STOP_LAST = 3'(STOP_BITS - 1);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_DATA   = 3'd2,
        S_PARITY = 3'd3,
        S_STOP   = 3'd4,
        S_BREAK  = 3'd5
    } state_t;

    // 2-of-3 majority vote of the three mid-bit samples.
    function automatic logic maj3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

    // Returns 1 when the received parity bit does not match the configured mode.
    function automatic logic parity_bad(input logic [DATA_BITS-1:0] d, input logic p);
        logic x;
        x = (^d) ^ p;
        if (PARITY == 32'sd1) begin
            return ~x;
        end else begin
            return x;
        end
    endfunction

    logic                 sync1_q, rxs_q;
    state_t               state_q, state_d;
    logic [CW-1:0]        cnt_q, cnt_d;
    logic [2:0]           bit_q, bit_d;
    logic [DATA_BITS-1:0] shreg_q, shreg_d;
    logic [1:0]           smp_q, smp_d;
    logic                 stop_err_q, stop_err_d;
    logic                 par_err_q, par_err_d;
    logic [DATA_BITS-1:0] data_q, data_d;
    logic                 valid_q, valid_d;
    logic                 frame_err_q, frame_err_d;
    logic                 parity_err_q, parity_err_d;
    logic                 overrun_q, overrun_d;
    logic                 busy_q, busy_d;

    logic maj_s, mid_s, last_s, done_s, done_fe_s, accept_s;

    assign maj_s  = maj3(smp_q[1], smp_q[0], rxs_q);
    assign mid_s  = (cnt_q == SMP_C);
    assign last_s = (cnt_q == CNT_LAST);

    // Receive FSM: bit timing, majority sampling, shifting and frame completion.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        bit_d      = bit_q;
        shreg_d    = shreg_q;
        smp_d      = smp_q;
        stop_err_d = stop_err_q;
        par_err_d  = par_err_q;
        done_s     = 1'b0;
        done_fe_s  = 1'b0;

        // Shared bit-period counter and early samples for the bit-timed states.
        if (state_q inside {S_START, S_DATA, S_PARITY, S_STOP}) begin
            cnt_d = last_s ? '0 : cnt_q + CNT_ONE;
            if (cnt_q == SMP_A) begin
                smp_d[1] = rxs_q;
            end else if (cnt_q == SMP_B) begin
                smp_d[0] = rxs_q;
            end else begin
                smp_d = smp_q;
            end
        end else begin
            cnt_d = '0;
        end

        case (state_q)
            S_IDLE: begin
                bit_d = 3'd0;
                if (!rxs_q) begin
                    // This cycle is count 0 of the start bit.
                    state_d    = S_START;
                    cnt_d      = CNT_ONE;
                    stop_err_d = 1'b0;
                    par_err_d  = 1'b0;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_START: begin
                if (mid_s && maj_s) begin
                    // Glitch: the line was not really low mid-bit.
                    state_d = S_IDLE;
                    cnt_d   = '0;
                end else if (last_s) begin
                    state_d = S_DATA;
                    bit_d   = 3'd0;
                end else begin
                    state_d = S_START;
                end
            end
            S_DATA: begin
                if (mid_s) begin
                    shreg_d = {maj_s, shreg_q[DATA_BITS-1:1]};
                end else if (last_s) begin
                    if (bit_q == DATA_LAST) begin
                        bit_d   = 3'd0;
                        state_d = (PARITY != 32'sd0) ? S_PARITY : S_STOP;
                    end else begin
                        bit_d = bit_q + 3'd1;
                    end
                end else begin
                    state_d = S_DATA;
                end
            end
            S_PARITY: begin
                if (mid_s) begin
                    par_err_d = parity_bad(shreg_q, maj_s);
                end else if (last_s) begin
                    state_d = S_STOP;
                    bit_d   = 3'd0;
                end else begin
                    state_d = S_PARITY;
                end
            end
            S_STOP: begin
                if (mid_s) begin
                    if (bit_q == STOP_LAST) begin
                        done_s    = 1'b1;
                        done_fe_s = stop_err_q | ~maj_s;
                        state_d   = done_fe_s ? S_BREAK : S_IDLE;
                        cnt_d     = '0;
                        bit_d     = 3'd0;
                    end else begin
                        stop_err_d = stop_err_q | ~maj_s;
                    end
                end else if (last_s) begin
                    bit_d = bit_q + 3'd1;
                end else begin
                    state_d = S_STOP;
                end
            end
            S_BREAK: begin
                // Hold here while the line stays low so a break yields one word.
                if (rxs_q) begin
                    state_d = S_IDLE;
                end else begin
                    state_d = S_BREAK;
                end
            end
            default: begin
                state_d = S_IDLE;
                cnt_d   = '0;
                bit_d   = 3'd0;
            end
        endcase
    end

    // Output holding register, handshake and sticky overrun.
    always_comb begin
        data_d       = data_q;
        valid_d      = valid_q;
        frame_err_d  = frame_err_q;
        parity_err_d = parity_err_q;
        overrun_d    = overrun_q;
        accept_s     = valid_q & ready;

        if (done_s && (!valid_q || ready)) begin
            data_d       = shreg_q;
            valid_d      = 1'b1;
            frame_err_d  = done_fe_s;
            parity_err_d = (PARITY != 32'sd0) ? par_err_q : 1'b0;
        end else if (accept_s) begin
            valid_d = 1'b0;
        end else begin
            valid_d = valid_q;
        end

        // A drop in the same cycle as an accept keeps the flag set.
        if (done_s && valid_q && !ready) begin
            overrun_d = 1'b1;
        end else if (accept_s) begin
            overrun_d = 1'b0;
        end else begin
            overrun_d = overrun_q;
        end

        busy_d = (state_d != S_IDLE);
    end

    // State and datapath registers; synchronizer resets to the idle level.
    always_ff @(posedge clock or negedge rst) begin
        if (!rst) begin
            sync1_q      <= 1'b1;
            rxs_q        <= 1'b1;
            state_q      <= S_IDLE;
            cnt_q        <= '0;
            bit_q        <= 3'd0;
            shreg_q      <= '0;
            smp_q        <= 2'b00;
            stop_err_q   <= 1'b0;
            par_err_q    <= 1'b0;
            data_q       <= '0;
            valid_q      <= 1'b0;
            frame_err_q  <= 1'b0;
            parity_err_q <= 1'b0;
            overrun_q    <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            sync1_q      <= rx;
            rxs_q        <= sync1_q;
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            bit_q        <= bit_d;
            shreg_q      <= shreg_d;
            smp_q        <= smp_d;
            stop_err_q   <= stop_err_d;
            par_err_q    <= par_err_d;
            data_q       <= data_d;
            valid_q      <= valid_d;
            frame_err_q  <= frame_err_d;
            parity_err_q <= parity_err_d;
            overrun_q    <= overrun_d;
            busy_q       <= busy_d;
        end
    end

    assign data       = data_q;
    assign valid      = valid_q;
    assign frame_err  = frame_err_q;
    assign parity_err = parity_err_q;
    assign overrun    = overrun_q;
    assign busy       = busy_q;

endmodule
